lsu_mem_stage: RTL

- Memory-access stage directly downstream of the ALU.
- Consumes the ALU's computed effective address (res_R) for load/store/flw/fsw opcodes.
- Runs a single outstanding data-memory transaction over a valid/ready request and valid response interface.
- Returns an aligned, sign/zero-extended load result to writeback, tagged for the integer or float register file.
- Non-memory opcodes pass through in one cycle with no memory activity.

---
 rtl/rv32s_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 120 ++++++++++++
 rtl/lsu_mem_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32s_pkg.sv
// ----------------------------------------------------------------------------
// rv32s_pkg
// Shared definitions for the RV32 load/store datapath:
//   - memory opcode constants (integer and float load/store)
//   - funct3 width codes for loads and stores
//   - lsu_state_t, the memory-stage transaction state
//   - small opcode classification helpers
// ----------------------------------------------------------------------------
package rv32s_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_FSW   = 7'b0100111;

    // Load width codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store width codes
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    function automatic logic is_load_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_FLW);
    endfunction

    function automatic logic is_store_op(input logic [6:0] op);
        return (op == OP_STORE) || (op == OP_FSW);
    endfunction

    function automatic logic is_fp_op(input logic [6:0] op);
        return (op == OP_FLW) || (op == OP_FSW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the memory stage.
//   Request side (live instruction fields, evaluated at acceptance):
//     st_funct3, st_addr_lo, st_is_load, st_is_store, st_is_fp, st_data
//     -> st_wdata (store data replicated to every lane), st_wstrb,
//        st_misalign (alignment or undefined-funct3 error)
//   Response side (fields latched at acceptance):
//     ld_funct3, ld_addr_lo, ld_is_fp, ld_rdata
//     -> ld_result (lane-extracted, sign/zero extended load value)
// Float accesses are always word sized; their funct3 is not decoded.
// ----------------------------------------------------------------------------
module lsu_align
    import rv32s_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_addr_lo,
    input  logic            st_is_load,
    input  logic            st_is_store,
    input  logic            st_is_fp,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] st_wdata,
    output logic [3:0]      st_wstrb,
    output logic            st_misalign,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic            ld_is_fp,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_result
);

    logic            st_bad_s;
    logic            ld_bad_s;
    logic [XLEN-1:0] shifted_s;

    // Store lane replication, byte strobes and store-side legality.
    always_comb begin
        st_wdata = '0;
        st_wstrb = 4'b0000;
        st_bad_s = 1'b0;
        if (st_is_fp) begin
            st_wdata = st_data;
            st_wstrb = 4'b1111;
            st_bad_s = (st_addr_lo != 2'b00);
        end else begin
            case (st_funct3)
                SB: begin
                    // Replicating the byte lets the strobe alone pick the lane.
                    st_wdata = {4{st_data[7:0]}};
                    st_wstrb = 4'b0001 << st_addr_lo;
                    st_bad_s = 1'b0;
                end
                SH: begin
                    st_wdata = {2{st_data[15:0]}};
                    st_wstrb = 4'b0011 << st_addr_lo;
                    st_bad_s = st_addr_lo[0];
                end
                SW: begin
                    st_wdata = st_data;
                    st_wstrb = 4'b1111;
                    st_bad_s = (st_addr_lo != 2'b00);
                end
                default: begin
                    st_wdata = '0;
                    st_wstrb = 4'b0000;
                    st_bad_s = 1'b1;
                end
            endcase
        end
    end

    // Load-side legality for the instruction being accepted.
    always_comb begin
        ld_bad_s = 1'b0;
        if (st_is_fp) begin
            ld_bad_s = (st_addr_lo != 2'b00);
        end else begin
            case (st_funct3)
                LB, LBU: ld_bad_s = 1'b0;
                LH, LHU: ld_bad_s = st_addr_lo[0];
                LW:      ld_bad_s = (st_addr_lo != 2'b00);
                default: ld_bad_s = 1'b1;
            endcase
        end
    end

    // Select the error flag matching the access direction.
    always_comb begin
        if (st_is_load) begin
            st_misalign = ld_bad_s;
        end else if (st_is_store) begin
            st_misalign = st_bad_s;
        end else begin
            st_misalign = 1'b0;
        end
    end

    // Bring the addressed byte lane down to bit 0.
    assign shifted_s = ld_rdata >> {ld_addr_lo, 3'b000};

    // Width extraction and sign/zero extension of the returned word.
    always_comb begin
        ld_result = '0;
        if (ld_is_fp) begin
            ld_result = ld_rdata;
        end else begin
            case (ld_funct3)
                LB:      ld_result = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
                LH:      ld_result = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
                LW:      ld_result = shifted_s;
                LBU:     ld_result = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
                LHU:     ld_result = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
                default: ld_result = '0;
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage
// Memory-access stage following the ALU. Accepts one instruction at a time
// and runs at most one data-memory transaction for it.
//   Upstream:   in_valid/in_ready, opcode, funct3, addr (effective address),
//               src2R (integer store data), src2F (float store data)
//   Memory:     mem_req_valid/mem_req_ready request handshake with mem_we,
//               word-aligned mem_addr, lane-replicated mem_wdata, mem_wstrb;
//               mem_rsp_valid/mem_rdata completion
//   Writeback:  out_valid (one-cycle pulse), out_data, out_is_fp, out_wen,
//               out_misalign -- all but out_valid hold until the next result
// Misaligned or undefined-width accesses and non-memory opcodes skip the
// memory and complete through DONE one cycle after acceptance.
// All outputs are registered; the FSM lives here, lane logic in lsu_align.
// ----------------------------------------------------------------------------
module lsu_mem_stage
    import rv32s_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] src2R,
    input  logic [XLEN-1:0] src2F,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic            out_is_fp,
    output logic            out_wen,
    output logic            out_misalign
);

    lsu_state_t      state_q, state_d;

    logic            in_ready_q, in_ready_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_is_fp_q, out_is_fp_d;
    logic            out_wen_q, out_wen_d;
    logic            out_misalign_q, out_misalign_d;

    // Fields kept for formatting the load response
    logic [2:0]      ld_funct3_q, ld_funct3_d;
    logic [1:0]      ld_addr_lo_q, ld_addr_lo_d;
    logic            ld_is_fp_q, ld_is_fp_d;
    logic            ld_is_load_q, ld_is_load_d;

    logic            op_load_s;
    logic            op_store_s;
    logic            op_fp_s;
    logic [XLEN-1:0] st_data_s;
    logic [XLEN-1:0] st_wdata_s;
    logic [3:0]      st_wstrb_s;
    logic            st_misalign_s;
    logic [XLEN-1:0] ld_result_s;

    assign op_load_s  = is_load_op(opcode);
    assign op_store_s = is_store_op(opcode);
    assign op_fp_s    = is_fp_op(opcode);
    assign st_data_s  = (opcode == OP_FSW) ? src2F : src2R;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_funct3   (funct3),
        .st_addr_lo  (addr[1:0]),
        .st_is_load  (op_load_s),
        .st_is_store (op_store_s),
        .st_is_fp    (op_fp_s),
        .st_data     (st_data_s),
        .st_wdata    (st_wdata_s),
        .st_wstrb    (st_wstrb_s),
        .st_misalign (st_misalign_s),
        .ld_funct3   (ld_funct3_q),
        .ld_addr_lo  (ld_addr_lo_q),
        .ld_is_fp    (ld_is_fp_q),
        .ld_rdata    (mem_rdata),
        .ld_result   (ld_result_s)
    );

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d        = state_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;
        out_data_d     = out_data_q;
        out_is_fp_d    = out_is_fp_q;
        out_wen_d      = out_wen_q;
        out_misalign_d = out_misalign_q;
        ld_funct3_d    = ld_funct3_q;
        ld_addr_lo_d   = ld_addr_lo_q;
        ld_is_fp_d     = ld_is_fp_q;
        ld_is_load_d   = ld_is_load_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op_load_s || op_store_s) begin
                        ld_funct3_d  = funct3;
                        ld_addr_lo_d = addr[1:0];
                        ld_is_fp_d   = op_fp_s;
                        ld_is_load_d = op_load_s;
                        if (st_misalign_s) begin
                            // Error path: report without touching memory.
                            state_d        = DONE;
                            out_data_d     = '0;
                            out_is_fp_d    = 1'b0;
                            out_wen_d      = 1'b0;
                            out_misalign_d = 1'b1;
                        end else begin
                            state_d    = REQ;
                            mem_we_d   = op_store_s;
                            mem_addr_d = {addr[XLEN-1:2], 2'b00};
                            if (op_store_s) begin
                                mem_wdata_d = st_wdata_s;
                                mem_wstrb_d = st_wstrb_s;
                            end else begin
                                mem_wdata_d = '0;
                                mem_wstrb_d = 4'b0000;
                            end
                        end
                    end else begin
                        // Non-memory instruction: a single bubble cycle.
                        state_d        = DONE;
                        out_data_d     = '0;
                        out_is_fp_d    = 1'b0;
                        out_wen_d      = 1'b0;
                        out_misalign_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                // Only reachable the cycle after the handshake, so a response
                // coincident with the handshake is never taken.
                if (mem_rsp_valid) begin
                    state_d        = DONE;
                    out_misalign_d = 1'b0;
                    if (ld_is_load_q) begin
                        out_data_d  = ld_result_s;
                        out_is_fp_d = ld_is_fp_q;
                        out_wen_d   = 1'b1;
                    end else begin
                        out_data_d  = '0;
                        out_is_fp_d = 1'b0;
                        out_wen_d   = 1'b0;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered views of the next state.
        in_ready_d      = (state_d == IDLE);
        mem_req_valid_d = (state_d == REQ);
        out_valid_d     = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            in_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= 4'b0000;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_is_fp_q     <= 1'b0;
            out_wen_q       <= 1'b0;
            out_misalign_q  <= 1'b0;
            ld_funct3_q     <= 3'b000;
            ld_addr_lo_q    <= 2'b00;
            ld_is_fp_q      <= 1'b0;
            ld_is_load_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_is_fp_q     <= out_is_fp_d;
            out_wen_q       <= out_wen_d;
            out_misalign_q  <= out_misalign_d;
            ld_funct3_q     <= ld_funct3_d;
            ld_addr_lo_q    <= ld_addr_lo_d;
            ld_is_fp_q      <= ld_is_fp_d;
            ld_is_load_q    <= ld_is_load_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_is_fp     = out_is_fp_q;
    assign out_wen       = out_wen_q;
    assign out_misalign  = out_misalign_q;

endmodule
